sram_ctrl: RTL and testbench

// - Memory-side responder to the MEM stage's data port: accepts ce/we/sel/addr/data requests and runs them on the

---
 rtl/sram_ctrl_if.sv | 32 +++
 rtl/sram_ctrl.sv | 134 +++++++++++++
 tb/tb_sram_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// Bundle between the MEM stage data port and the board SRAM pins.
// The slave modport is the controller; master is the MEM stage plus SRAM chips.
interface sram_ctrl_if;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] maddr_i;
  logic [31:0] mdata_i;
  logic [3:0]  msel_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        ram_sel_o;
  logic [19:0] ram_addr_o;
  logic [31:0] ram_data_i;
  logic [31:0] ram_data_o;
  logic        ram_data_oe;
  logic [3:0]  ram_be_n;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;

  modport slave (
    input  mem_ce_i, mem_we_i, maddr_i, mdata_i, msel_i, ram_data_i,
    output rdata_o, stall_o, ram_sel_o, ram_addr_o, ram_data_o, ram_data_oe,
           ram_be_n, ram_ce_n, ram_oe_n, ram_we_n
  );

  modport master (
    output mem_ce_i, mem_we_i, maddr_i, mdata_i, msel_i, ram_data_i,
    input  rdata_o, stall_o, ram_sel_o, ram_addr_o, ram_data_o, ram_data_oe,
           ram_be_n, ram_ce_n, ram_oe_n, ram_we_n
  );
endinterface

// File: rtl/sram_ctrl.sv
// SRAM controller: runs MEM-stage requests on the base/ext SRAM and stalls until done.
// Optional macro SRAM_WR_RECOVERY_EN adds one idle RECOVER cycle after every write.
//
// state   | meaning
// IDLE    | waiting for a request; stall follows mem_ce_i
// ACCESS  | strobes active for WAIT_CYCLES+1 cycles
// DONE    | access finished, pipeline released for one cycle
// RECOVER | (SRAM_WR_RECOVERY_EN only) bus turnaround after a write
module sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic        clk,
  input logic        rst,
  sram_ctrl_if.slave bus
);

  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

`ifdef SRAM_WR_RECOVERY_EN
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, RECOVER} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [19:0]   addr_q, addr_d;
  logic          bank_q, bank_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          in_range;
  logic          unused_addr_bits;

  assign in_range         = (bus.maddr_i[31:23] == 9'h100);
  assign unused_addr_bits = ^bus.maddr_i[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      addr_q  <= 20'h0;
      bank_q  <= 1'b0;
      data_q  <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    we_d            = we_q;
    sel_d           = sel_q;
    addr_d          = addr_q;
    bank_d          = bank_q;
    data_d          = data_q;
    rdata_d         = rdata_q;
    bus.stall_o     = 1'b0;
    bus.ram_ce_n    = 1'b1;
    bus.ram_oe_n    = 1'b1;
    bus.ram_we_n    = 1'b1;
    bus.ram_be_n    = 4'hF;
    bus.ram_data_oe = 1'b0;
    case (state_q)
      IDLE: begin
        bus.stall_o = bus.mem_ce_i;
        if (bus.mem_ce_i) begin
          we_d = bus.mem_we_i;
          if (in_range) begin
            sel_d   = bus.msel_i;
            addr_d  = bus.maddr_i[21:2];
            bank_d  = bus.maddr_i[22];
            data_d  = bus.mdata_i;
            cnt_d   = CW'(WAIT_CYCLES);
            state_d = ACCESS;
          end else begin
            if (!bus.mem_we_i) rdata_d = 32'h0;
            state_d = DONE;
          end
        end
      end
      ACCESS: begin
        bus.stall_o  = 1'b1;
        bus.ram_ce_n = 1'b0;
        bus.ram_be_n = ~sel_q;
        if (we_q) begin
          bus.ram_data_oe = 1'b1;
          // release we_n one cycle early so data is held past the rising strobe
          bus.ram_we_n    = (cnt_q == '0);
        end else begin
          bus.ram_oe_n = 1'b0;
        end
        if (cnt_q == '0) begin
          if (!we_q) rdata_d = bus.ram_data_i;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
`ifdef SRAM_WR_RECOVERY_EN
        state_d = we_q ? RECOVER : IDLE;
`else
        state_d = IDLE;
`endif
      end
`ifdef SRAM_WR_RECOVERY_EN
      RECOVER: begin
        bus.stall_o = bus.mem_ce_i;
        state_d     = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign bus.rdata_o    = rdata_q;
  assign bus.ram_sel_o  = bank_q;
  assign bus.ram_addr_o = addr_q;
  assign bus.ram_data_o = data_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: directed scenarios plus random traffic
// checked against a word-array memory model and request-level timing rules.
module tb_sram_ctrl;
  localparam int W1 = 1;
  localparam int W3 = 3;
`ifdef SRAM_WR_RECOVERY_EN
  localparam bit REC = 1'b1;
`else
  localparam bit REC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_ctrl_if mif1();
  sram_ctrl_if mif3();

  sram_ctrl #(.WAIT_CYCLES(W1)) dut1 (.clk(clk), .rst(rst), .bus(mif1.slave));
  sram_ctrl #(.WAIT_CYCLES(W3)) dut3 (.clk(clk), .rst(rst), .bus(mif3.slave));

  assign mif3.ram_data_i = 32'h1234_5678;

  int checks = 0;
  int failures = 0;
  logic [31:0] sram_mem [logic [20:0]];
  logic [31:0] ref_mem  [logic [20:0]];
  logic [31:0] exp_rdata1 = 32'h0;
  bit          prev_wr = 1'b0;

  function automatic logic [31:0] init_word(input logic [20:0] k);
    return {11'h2A5, k} ^ 32'hC3C3_0000;
  endfunction

  // SRAM chip model on dut1's pins: byte writes while ce_n/we_n low, read data on oe_n
  always @(negedge clk) begin : sram_model
    logic [20:0] k;
    logic [31:0] w;
    k = {mif1.ram_sel_o, mif1.ram_addr_o};
    w = sram_mem.exists(k) ? sram_mem[k] : init_word(k);
    if (!mif1.ram_ce_n && !mif1.ram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!mif1.ram_be_n[b]) w[8*b +: 8] = mif1.ram_data_o[8*b +: 8];
      sram_mem[k] = w;
    end
    mif1.ram_data_i = (!mif1.ram_ce_n && !mif1.ram_oe_n) ? w : $urandom;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      mif1.mem_ce_i = 1'b0;
    end
  endtask

  task automatic do_op(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] data, input bit b2b, input bit wiggle,
                       input string name);
    bit          in_range;
    logic [20:0] k;
    logic [31:0] w;
    int stall_n = 0, oe_cnt = 0, we_cnt = 0, ce_cnt = 0, hold_cnt = 0, bad_pins = 0;
    int exp_stall;
    in_range  = (addr[31:23] == 9'h100);
    k         = addr[22:2];
    exp_stall = in_range ? W1 + 2 : 1;
    if (REC && b2b && prev_wr) exp_stall++;
    if (in_range && we) begin
      w = ref_mem.exists(k) ? ref_mem[k] : init_word(k);
      for (int b = 0; b < 4; b++)
        if (sel[b]) w[8*b +: 8] = data[8*b +: 8];
      ref_mem[k] = w;
    end
    if (!we) exp_rdata1 = !in_range ? 32'h0 : (ref_mem.exists(k) ? ref_mem[k] : init_word(k));

    @(posedge clk); #1;
    mif1.mem_ce_i = 1'b1;
    mif1.mem_we_i = we;
    mif1.maddr_i  = addr;
    mif1.msel_i   = sel;
    mif1.mdata_i  = data;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (wiggle && c == 1) begin
        mif1.maddr_i = $urandom;
        mif1.mdata_i = $urandom;
        mif1.msel_i  = 4'($urandom);
      end
      if (!mif1.ram_ce_n) begin
        ce_cnt++;
        if (mif1.ram_addr_o !== addr[21:2] || mif1.ram_sel_o !== addr[22] ||
            mif1.ram_be_n !== ~sel) bad_pins++;
      end
      if (!mif1.ram_oe_n) oe_cnt++;
      if (!mif1.ram_we_n) we_cnt++;
      if (!mif1.ram_ce_n && mif1.ram_data_oe && mif1.ram_we_n) hold_cnt++;
      if (mif1.ram_data_oe && mif1.ram_data_o !== data) bad_pins++;
      if (mif1.ram_data_oe && !mif1.ram_oe_n) bad_pins++;
      if (!mif1.stall_o) break;
      stall_n++;
    end

    checks++;
    if (stall_n !== exp_stall) begin
      failures++; $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stall_n, exp_stall);
    end
    checks++;
    if (ce_cnt !== (in_range ? W1 + 1 : 0)) begin
      failures++; $display("FAIL %s ce_n_low got=%0d exp=%0d", name, ce_cnt, in_range ? W1 + 1 : 0);
    end
    checks++;
    if (oe_cnt !== ((in_range && !we) ? W1 + 1 : 0)) begin
      failures++; $display("FAIL %s oe_n_low got=%0d exp=%0d", name, oe_cnt, (in_range && !we) ? W1 + 1 : 0);
    end
    checks++;
    if (we_cnt !== ((in_range && we) ? W1 : 0)) begin
      failures++; $display("FAIL %s we_n_low got=%0d exp=%0d", name, we_cnt, (in_range && we) ? W1 : 0);
    end
    checks++;
    if (hold_cnt !== ((in_range && we) ? 1 : 0)) begin
      failures++; $display("FAIL %s data_hold got=%0d exp=%0d", name, hold_cnt, (in_range && we) ? 1 : 0);
    end
    checks++;
    if (bad_pins !== 0) begin
      failures++; $display("FAIL %s pin_values bad_cycles got=%0d exp=0", name, bad_pins);
    end
    checks++;
    if (mif1.rdata_o !== exp_rdata1) begin
      failures++; $display("FAIL %s rdata got=%h exp=%h", name, mif1.rdata_o, exp_rdata1);
    end
    prev_wr = we;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mif1.mem_ce_i = 1'b0; mif1.mem_we_i = 1'b0; mif1.maddr_i = 32'h0;
    mif1.mdata_i = 32'h0; mif1.msel_i = 4'h0;
    mif3.mem_ce_i = 1'b0; mif3.mem_we_i = 1'b0; mif3.maddr_i = 32'h0;
    mif3.mdata_i = 32'h0; mif3.msel_i = 4'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mif1.ram_ce_n, mif1.ram_oe_n, mif1.ram_we_n, mif1.ram_data_oe, mif1.stall_o} !== 5'b11100) begin
      failures++; $display("FAIL reset_strobes got=%b exp=11100",
        {mif1.ram_ce_n, mif1.ram_oe_n, mif1.ram_we_n, mif1.ram_data_oe, mif1.stall_o});
    end
    checks++;
    if (mif1.ram_be_n !== 4'hF) begin
      failures++; $display("FAIL reset_be_n got=%h exp=f", mif1.ram_be_n);
    end
    checks++;
    if ({mif1.rdata_o, mif1.ram_data_o, mif1.ram_addr_o, mif1.ram_sel_o} !== 85'h0) begin
      failures++; $display("FAIL reset_regs rdata=%h data_o=%h addr=%h sel=%b exp all zero",
        mif1.rdata_o, mif1.ram_data_o, mif1.ram_addr_o, mif1.ram_sel_o);
    end
    mif1.mem_ce_i = 1'b1;
    #1;
    checks++;
    if (mif1.stall_o !== 1'b1) begin
      failures++; $display("FAIL reset_idle_stall got=%b exp=1", mif1.stall_o);
    end
    mif1.mem_ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read();
    sram_mem[21'h4] = 32'hDEAD_BEEF;
    ref_mem[21'h4]  = 32'hDEAD_BEEF;
    do_op(1'b0, 32'h8000_0010, 4'hF, 32'h0, 1'b0, 1'b0, "read");
    idle(2);
  endtask

  task automatic test_byte_write();
    do_op(1'b1, 32'h8040_0003, 4'b1000, 32'hAB00_0000, 1'b0, 1'b0, "byte_write");
    idle(2);
    do_op(1'b0, 32'h8040_0000, 4'hF, 32'h0, 1'b0, 1'b0, "byte_write_rb");
    idle(2);
  endtask

  task automatic test_out_of_range();
    do_op(1'b0, 32'h1FD0_03F8, 4'hF, 32'h0, 1'b0, 1'b0, "out_of_range");
    idle(2);
  endtask

  task automatic test_back_to_back();
    do_op(1'b1, 32'h8000_0000, 4'hF, $urandom, 1'b0, 1'b0, "b2b_write");
    do_op(1'b0, 32'h8000_0000, 4'hF, 32'h0, 1'b1, 1'b0, "b2b_read");
    idle(2);
  endtask

  task automatic test_stall_change();
    do_op(1'b1, 32'h8000_0100, 4'b0011, $urandom, 1'b0, 1'b1, "stall_change_wr");
    idle(1);
    do_op(1'b0, 32'h8000_0104, 4'hF, 32'h0, 1'b0, 1'b1, "stall_change_rd");
    idle(1);
    do_op(1'b0, 32'h8000_0100, 4'hF, 32'h0, 1'b0, 1'b0, "stall_change_rb");
    idle(2);
  endtask

  task automatic test_random();
    int gap = 1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      bit we;
      we = 1'($urandom);
      if ($urandom_range(0, 9) < 8) begin
        a = 32'h8000_0000 | (32'($urandom_range(0, 1)) << 22) |
            (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      end else begin
        a = $urandom;
        if (a[31:23] == 9'h100) a[31] = 1'b0;
        we = 1'b0;
      end
      do_op(we, a, 4'($urandom), $urandom, gap == 0, 1'b0, "random");
      gap = $urandom_range(0, 2);
      idle(gap);
    end
    idle(2);
  endtask

  task automatic test_reset_mid_access();
    int ce_seen = 0, stall_seen = 0, lat = 0;
    @(posedge clk); #1;
    mif3.mem_ce_i = 1'b1; mif3.mem_we_i = 1'b1; mif3.maddr_i = 32'h8000_0040;
    mif3.msel_i = 4'hF; mif3.mdata_i = $urandom;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mif3.ram_ce_n, mif3.ram_we_n, mif3.ram_data_oe} !== 3'b001) begin
      failures++; $display("FAIL rst_mid_pre got=%b exp=001",
        {mif3.ram_ce_n, mif3.ram_we_n, mif3.ram_data_oe});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mif3.ram_ce_n, mif3.ram_we_n, mif3.ram_data_oe, mif3.stall_o} !== 4'b1101) begin
      failures++; $display("FAIL rst_mid_strobes got=%b exp=1101",
        {mif3.ram_ce_n, mif3.ram_we_n, mif3.ram_data_oe, mif3.stall_o});
    end
    mif3.mem_ce_i = 1'b0;
    #1;
    checks++;
    if (mif3.stall_o !== 1'b0) begin
      failures++; $display("FAIL rst_mid_idle_stall got=%b exp=0", mif3.stall_o);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_rdata1 = 32'h0;
    prev_wr = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (!mif3.ram_ce_n) ce_seen++;
      if (mif3.stall_o) stall_seen++;
    end
    checks++;
    if (ce_seen !== 0 || stall_seen !== 0) begin
      failures++; $display("FAIL rst_mid_no_done ce_cycles=%0d stall_cycles=%0d exp=0", ce_seen, stall_seen);
    end
    @(posedge clk); #1;
    mif3.mem_ce_i = 1'b1; mif3.mem_we_i = 1'b0; mif3.maddr_i = 32'h8000_0044;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!mif3.stall_o) break;
      lat++;
    end
    checks++;
    if (lat !== W3 + 2 || mif3.rdata_o !== 32'h1234_5678) begin
      failures++; $display("FAIL w3_read stall_cycles=%0d exp=%0d rdata=%h exp=12345678",
        lat, W3 + 2, mif3.rdata_o);
    end
    @(posedge clk); #1;
    mif3.mem_ce_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_byte_write();
    test_out_of_range();
    test_back_to_back();
    test_stall_change();
    test_random();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
